// File: rtl/bank_timing_guard.sv
// bank_timing_guard: per-bank DRAM timing gate between the bank FSM and the command bus
module bank_timing_guard #(
  parameter int T_RCD = 14,
  parameter int T_RAS = 33,
  parameter int T_RP  = 14,
  parameter int T_RTP = 8,
  parameter int T_WR  = 15,
  parameter int T_CCD = 4,
  parameter int T_RFC = 110,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [2:0]  req_cmd,
  input  logic [15:0] req_addr,
  output logic        req_ready,
  output logic        stall,
  output logic        issue_valid,
  output logic [2:0]  issue_cmd,
  output logic [15:0] issue_addr,
  output logic        row_open,
  output logic        proto_err
);
  localparam logic [2:0] NOP = 3'd0, ACT = 3'd1, RD = 3'd2, WR = 3'd3, PRE = 3'd4, REF = 3'd5;
  logic [CNT_W-1:0] rcd, ras, rp, rtp, wr, ccd, rfc;
  logic is_act, is_rd, is_wr, is_pre, is_ref, illegal, elig, accept;
  function automatic logic [CNT_W-1:0] dec(input logic [CNT_W-1:0] c);
    return c == '0 ? c : c - CNT_W'(1);
  endfunction
  // Decode the request and decide eligibility; illegal commands are swallowed so the FSM never deadlocks
  always_comb begin
    is_act = req_cmd == ACT;
    is_rd = req_cmd == RD;
    is_wr = req_cmd == WR;
    is_pre = req_cmd == PRE;
    is_ref = req_cmd == REF;
    illegal = ((is_act | is_ref) & row_open) | ((is_rd | is_wr) & ~row_open) | (req_cmd[2] & req_cmd[1]);
    elig = (is_act | is_ref) ? (rp == '0 && rfc == '0) :
           (is_rd | is_wr) ? (rcd == '0 && ccd == '0) :
           is_pre ? (ras == '0 && rtp == '0 && wr == '0) : 1'b1;
    req_ready = req_valid & (illegal | elig);
    accept = req_valid & elig & ~illegal & (req_cmd != NOP);
  end
  assign stall = req_valid & ~req_ready;
  // Interval counters: load on the owning command, otherwise count down and hold at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {rcd, ras, rp, rtp, wr, ccd, rfc} <= '0;
    end else begin
      rcd <= accept && is_act ? CNT_W'(T_RCD - 1) : dec(rcd);
      ras <= accept && is_act ? CNT_W'(T_RAS - 1) : dec(ras);
      rp <= accept && is_pre ? CNT_W'(T_RP - 1) : dec(rp);
      rtp <= accept && is_rd ? CNT_W'(T_RTP - 1) : dec(rtp);
      wr <= accept && is_wr ? CNT_W'(T_WR - 1) : dec(wr);
      ccd <= accept && (is_rd || is_wr) ? CNT_W'(T_CCD - 1) : dec(ccd);
      rfc <= accept && is_ref ? CNT_W'(T_RFC - 1) : dec(rfc);
    end
  end
  // Registered command bus, bank open state and sticky protocol error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_valid <= 1'b0;
      issue_cmd <= '0;
      issue_addr <= '0;
      row_open <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      issue_valid <= accept;
      issue_cmd <= accept ? req_cmd : issue_cmd;
      issue_addr <= accept ? req_addr : issue_addr;
      row_open <= accept && is_act ? 1'b1 : accept && is_pre ? 1'b0 : row_open;
      proto_err <= proto_err | (req_valid & illegal);
    end
  end
endmodule
